// File: rtl/mpeg2_sequence_ctrl.sv
// mpeg2_sequence_ctrl
//   Runs one MPEG2 encode sequence through mpeg2encoder. It accepts a
//   per-sequence configuration (frame size in 16-pixel units and frame
//   count). It forwards 4-pixel YUV444 beats to the encoder with a latency
//   of one cycle, and tracks column, row and frame position while it does
//   so. At the end of the sequence it issues the single-cycle sequence-stop
//   pulse. It then waits for the encoder to drain before it accepts another
//   configuration.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   cfg_valid/cfg_ready    configuration handshake (ready only in IDLE)
//   cfg_xsize16/ysize16    frame size / 16, each must be 4..(1<<XL / 1<<YL)
//   cfg_nframes            frames to encode, 0 = run until abort
//   cfg_err                one-cycle pulse when a configuration is rejected
//   abort                  stop at the next frame boundary
//   s_valid/s_ready/s_sof/s_pix   pixel beat input {Y0..Y3,U0..U3,V0..V3}
//   enc_*                  encoder interface
//   busy                   high whenever not IDLE
//   done                   one-cycle pulse on return to IDLE
//   frame_cnt              frames fully forwarded (saturating)
//   sof_err                sticky start-of-frame alignment error
//
// Build option
//   MPEG2_SEQ_CTRL_SOF_CHECK_EN : when defined, each accepted beat's s_sof
//   is compared against the frame position. When undefined, s_sof has no
//   effect and sof_err stays 0.
module mpeg2_sequence_ctrl #(
   parameter int XL = 6,
   parameter int YL = 6,
   parameter int FW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cfg_valid,
   output logic          cfg_ready,
   input  logic [XL:0]   cfg_xsize16,
   input  logic [YL:0]   cfg_ysize16,
   input  logic [FW-1:0] cfg_nframes,
   output logic          cfg_err,
   input  logic          abort,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic          s_sof,
   input  logic [95:0]   s_pix,
   output logic [XL:0]   enc_xsize16,
   output logic [YL:0]   enc_ysize16,
   output logic          enc_en,
   output logic [95:0]   enc_pix,
   output logic          enc_sequence_stop,
   input  logic          enc_sequence_busy,
   output logic          busy,
   output logic          done,
   output logic [FW-1:0] frame_cnt,
   output logic          sof_err
);
   typedef enum logic [2:0] {IDLE, WAIT_ENC, STREAM, STOP, DRAIN} state_t;

   // cx counts 4-pixel beats across a row, ry counts pixel rows
   localparam int CXW = XL + 3;
   localparam int RYW = YL + 5;
   localparam logic [XL:0] X_MIN = (XL+1)'(4);
   localparam logic [XL:0] X_MAX = (XL+1)'(1) << XL;
   localparam logic [YL:0] Y_MIN = (YL+1)'(4);
   localparam logic [YL:0] Y_MAX = (YL+1)'(1) << YL;

   state_t        state_reg, state_next;
   logic [XL:0]   xsize_reg;
   logic [YL:0]   ysize_reg;
   logic [FW-1:0] nframes_reg;
   logic [CXW-1:0] cx_reg;
   logic [RYW-1:0] ry_reg;
   logic [FW-1:0] frame_cnt_reg;
   logic          abort_reg;
   logic          enc_en_reg;
   logic [95:0]   enc_pix_reg;
   logic          stop_reg;
   logic          cfg_err_reg;
   logic          done_reg;
   logic [1:0]    drain_cnt_reg;
   logic          sof_err_reg;

   logic          cfg_ok;
   logic          cfg_take;
   logic          cx_last;
   logic          ry_last;
   logic          at_boundary;
   logic          abort_any;
   logic          stop_now;
   logic          accept;
   logic          frame_end;
   logic [FW-1:0] frame_cnt_inc;
   logic          count_done;

   assign cfg_ok = (cfg_xsize16 >= X_MIN) && (cfg_xsize16 <= X_MAX) &&
                   (cfg_ysize16 >= Y_MIN) && (cfg_ysize16 <= Y_MAX);
   assign cfg_take = (state_reg == IDLE) && cfg_valid && cfg_ok;

   assign cx_last     = (cx_reg == ({xsize_reg, 2'b00} - CXW'(1)));
   assign ry_last     = (ry_reg == ({ysize_reg, 4'b0000} - RYW'(1)));
   assign at_boundary = (cx_reg == '0) && (ry_reg == '0);
   assign abort_any   = abort | abort_reg;

   // An abort seen while sitting on a frame boundary refuses the next beat
   // immediately, so no partial frame is ever started.
   assign stop_now  = (state_reg == STREAM) && abort_any && at_boundary;
   assign accept    = s_valid && s_ready;
   assign frame_end = accept && cx_last && ry_last;

   assign frame_cnt_inc = (&frame_cnt_reg) ? frame_cnt_reg : frame_cnt_reg + FW'(1);
   assign count_done    = (nframes_reg != '0) && (frame_cnt_inc == nframes_reg);

   always_comb begin
      state_next = state_reg;
      s_ready    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (cfg_take) state_next = WAIT_ENC;
         end
         WAIT_ENC: begin
            if (!enc_sequence_busy) state_next = STREAM;
         end
         STREAM: begin
            s_ready = !stop_now;
            if (stop_now) begin
               state_next = STOP;
            end else if (frame_end && (count_done || abort_any)) begin
               state_next = STOP;
            end
         end
         STOP: begin
            state_next = DRAIN;
         end
         DRAIN: begin
            if ((drain_cnt_reg == 2'd2) && !enc_sequence_busy) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         xsize_reg     <= '0;
         ysize_reg     <= '0;
         nframes_reg   <= '0;
         cx_reg        <= '0;
         ry_reg        <= '0;
         frame_cnt_reg <= '0;
         abort_reg     <= 1'b0;
         enc_en_reg    <= 1'b0;
         enc_pix_reg   <= '0;
         stop_reg      <= 1'b0;
         cfg_err_reg   <= 1'b0;
         done_reg      <= 1'b0;
         drain_cnt_reg <= '0;
         sof_err_reg   <= 1'b0;
      end else begin
         state_reg   <= state_next;
         enc_en_reg  <= accept;
         if (accept) enc_pix_reg <= s_pix;
         cfg_err_reg <= (state_reg == IDLE) && cfg_valid && !cfg_ok;
         // STOP lasts one cycle right after the last beat was accepted, so
         // the registered pulse lands one cycle after the final enc_en.
         stop_reg    <= (state_reg == STOP);
         done_reg    <= (state_reg == DRAIN) && (state_next == IDLE);
         abort_reg   <= (state_reg == STREAM) && abort_any;

         if (state_reg == STOP) begin
            drain_cnt_reg <= '0;
         end else if ((state_reg == DRAIN) && (drain_cnt_reg != 2'd2)) begin
            drain_cnt_reg <= drain_cnt_reg + 2'd1;
         end

         if (cfg_take) begin
            xsize_reg     <= cfg_xsize16;
            ysize_reg     <= cfg_ysize16;
            nframes_reg   <= cfg_nframes;
            cx_reg        <= '0;
            ry_reg        <= '0;
            frame_cnt_reg <= '0;
            sof_err_reg   <= 1'b0;
         end else if (accept) begin
            if (cx_last) begin
               cx_reg <= '0;
               ry_reg <= ry_last ? '0 : ry_reg + RYW'(1);
            end else begin
               cx_reg <= cx_reg + CXW'(1);
            end
            if (frame_end) frame_cnt_reg <= frame_cnt_inc;
`ifdef MPEG2_SEQ_CTRL_SOF_CHECK_EN
            // The beat is still forwarded and the counters keep their own
            // position; only the flag records the misalignment.
            if (s_sof != at_boundary) sof_err_reg <= 1'b1;
`else
            // The flag starts at 0 and the AND keeps it at 0. s_sof is
            // still consumed so it has a defined load.
            sof_err_reg <= sof_err_reg & s_sof;
`endif
         end
      end
   end

   assign cfg_ready         = (state_reg == IDLE);
   assign busy              = (state_reg != IDLE);
   assign cfg_err           = cfg_err_reg;
   assign done              = done_reg;
   assign enc_xsize16       = xsize_reg;
   assign enc_ysize16       = ysize_reg;
   assign enc_en            = enc_en_reg;
   assign enc_pix           = enc_pix_reg;
   assign enc_sequence_stop = stop_reg;
   assign frame_cnt         = frame_cnt_reg;
   assign sof_err           = sof_err_reg;

endmodule

// File: tb/tb_mpeg2_sequence_ctrl.sv
module tb_mpeg2_sequence_ctrl;
   localparam int XL  = 6;
   localparam int YL  = 6;
   localparam int FW  = 16;
   localparam int BPF = 1024;   // beats per 4x4 (64x64 pixel) frame
`ifdef MPEG2_SEQ_CTRL_SOF_CHECK_EN
   localparam logic SOF_EXP = 1'b1;
`else
   localparam logic SOF_EXP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [XL:0]   cfg_xsize16;
   logic [YL:0]   cfg_ysize16;
   logic [FW-1:0] cfg_nframes;
   logic          cfg_err;
   logic          abort;
   logic          s_valid;
   logic          s_ready;
   logic          s_sof;
   logic [95:0]   s_pix;
   logic [XL:0]   enc_xsize16;
   logic [YL:0]   enc_ysize16;
   logic          enc_en;
   logic [95:0]   enc_pix;
   logic          enc_sequence_stop;
   logic          enc_sequence_busy;
   logic          busy;
   logic          done;
   logic [FW-1:0] frame_cnt;
   logic          sof_err;

   always #5 clk = ~clk;

   mpeg2_sequence_ctrl #(.XL(XL), .YL(YL), .FW(FW)) dut (
      .clk(clk), .rst(rst),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_xsize16(cfg_xsize16), .cfg_ysize16(cfg_ysize16),
      .cfg_nframes(cfg_nframes), .cfg_err(cfg_err),
      .abort(abort),
      .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof), .s_pix(s_pix),
      .enc_xsize16(enc_xsize16), .enc_ysize16(enc_ysize16),
      .enc_en(enc_en), .enc_pix(enc_pix),
      .enc_sequence_stop(enc_sequence_stop),
      .enc_sequence_busy(enc_sequence_busy),
      .busy(busy), .done(done), .frame_cnt(frame_cnt), .sof_err(sof_err)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: samples on the falling edge, between active edges.
   logic [95:0] exp_q[$];
   logic [95:0] mon_pix;
   int beats_acc = 0, enc_cnt = 0, stop_cnt = 0, done_cnt = 0;
   int last_en_cyc = -10, last_stop_cyc = -10, last_done_cyc = -10;

   always @(negedge clk) begin
      if (enc_en === 1'b1) begin
         enc_cnt++;
         last_en_cyc = cyc;
         if (exp_q.size() == 0) begin
            check("enc_en_unexpected", 1, 0);
         end else begin
            mon_pix = exp_q.pop_front();
            check("enc_pix", enc_pix, mon_pix);
         end
      end
      if (enc_sequence_stop === 1'b1) begin
         stop_cnt++;
         last_stop_cyc = cyc;
         check("stop_overlaps_en", enc_en, 0);
      end
      if (done === 1'b1) begin
         done_cnt++;
         last_done_cyc = cyc;
      end
      if (rst) exp_q.delete();
      else if (s_valid && s_ready === 1'b1) begin
         exp_q.push_back(s_pix);
         beats_acc++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_cfg(input logic [XL:0] xs, input logic [YL:0] ys, input logic [FW-1:0] nf);
      cfg_valid   = 1'b1;
      cfg_xsize16 = xs;
      cfg_ysize16 = ys;
      cfg_nframes = nf;
      tick();
      cfg_valid = 1'b0;
   endtask

   // Drives beats until a stop pulse is seen. s_sof follows the beat index,
   // except that it is inverted on beat sof_bad_at. abort pulses once after
   // abort_at beats.
   task automatic stream(input int valid_pct, input int abort_at, input int sof_bad_at, input int bound);
      int s0 = stop_cnt;
      int base = beats_acc;
      bit aborted = 1'b0;
      int n = 0;
      while (stop_cnt == s0 && n < bound) begin
         s_valid = ($urandom_range(99) < valid_pct);
         s_pix   = {$urandom(), $urandom(), $urandom()};
         s_sof   = (((beats_acc - base) % BPF) == 0) ^ ((beats_acc - base) == sof_bad_at);
         abort   = !aborted && (abort_at >= 0) && ((beats_acc - base) >= abort_at);
         if (abort) aborted = 1'b1;
         tick();
         n++;
      end
      s_valid = 1'b0;
      s_sof   = 1'b0;
      abort   = 1'b0;
      check("stream_stop_seen", stop_cnt - s0, 1);
   endtask

   task automatic wait_done(input int bound);
      int d0 = done_cnt;
      int n = 0;
      while (done_cnt == d0 && n < bound) begin
         tick();
         n++;
      end
      check("done_seen", done_cnt - d0, 1);
   endtask

   typedef struct {
      logic [XL:0] xs;
      logic [YL:0] ys;
      logic        exp_err;
   } cfg_vec_t;

   cfg_vec_t vec [8];

   initial begin
      int e0, b0, s0, d0, fall;
      logic [XL:0] exp_x;
      logic [YL:0] exp_y;

      vec[0] = '{7'd3,  7'd4,  1'b1};
      vec[1] = '{7'd4,  7'd65, 1'b1};
      vec[2] = '{7'd0,  7'd4,  1'b1};
      vec[3] = '{7'd4,  7'd3,  1'b1};
      vec[4] = '{7'd65, 7'd64, 1'b1};
      vec[5] = '{7'd4,  7'd4,  1'b0};
      vec[6] = '{7'd64, 7'd64, 1'b0};
      vec[7] = '{7'd5,  7'd64, 1'b0};

      rst = 1'b1; cfg_valid = 1'b0; cfg_xsize16 = '0; cfg_ysize16 = '0;
      cfg_nframes = '0; abort = 1'b0; s_valid = 1'b0; s_sof = 1'b0;
      s_pix = '0; enc_sequence_busy = 1'b0;
      repeat (3) tick();
      check("rst_cfg_ready", cfg_ready, 1);
      check("rst_s_ready", s_ready, 0);
      check("rst_enc_en", enc_en, 0);
      check("rst_enc_pix", enc_pix, 0);
      check("rst_stop", enc_sequence_stop, 0);
      check("rst_enc_xsize", enc_xsize16, 0);
      check("rst_enc_ysize", enc_ysize16, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_cfg_err", cfg_err, 0);
      check("rst_frame_cnt", frame_cnt, 0);
      check("rst_sof_err", sof_err, 0);
      rst = 1'b0;
      tick();

      // Range-check table. Accepted rows are closed with a zero-frame abort.
      exp_x = '0;
      exp_y = '0;
      for (int i = 0; i < 8; i++) begin
         e0 = enc_cnt; s0 = stop_cnt;
         do_cfg(vec[i].xs, vec[i].ys, 16'd3);
         if (!vec[i].exp_err) begin
            exp_x = vec[i].xs;
            exp_y = vec[i].ys;
         end
         check("vec_cfg_err", cfg_err, vec[i].exp_err);
         check("vec_busy", busy, !vec[i].exp_err);
         check("vec_enc_xsize", enc_xsize16, exp_x);
         check("vec_enc_ysize", enc_ysize16, exp_y);
         if (vec[i].exp_err) begin
            tick();
            check("vec_cfg_err_pulse", cfg_err, 0);
            check("vec_still_idle", busy, 0);
         end else begin
            abort = 1'b1;
            wait_done(30);
            abort = 1'b0;
            check("zero_abort_stops", stop_cnt - s0, 1);
            check("zero_abort_no_en", enc_cnt - e0, 0);
         end
         $display("vec %0d: xs=%0d ys=%0d cfg_err=%0b busy=%0b", i, vec[i].xs, vec[i].ys, cfg_err, busy);
      end

      // Two frames, continuous beats, the encoder stays busy 50 cycles after stop.
      e0 = enc_cnt; b0 = beats_acc;
      do_cfg(7'd4, 7'd4, 16'd2);
      check("main_cfg_ready_drop", cfg_ready, 0);
      check("main_busy", busy, 1);
      tick();
      enc_sequence_busy = 1'b1;
      stream(100, -1, -1, 5000);
      check("main_enc_count", enc_cnt - e0, 2048);
      check("main_beat_count", beats_acc - b0, 2048);
      check("main_stop_after_en", last_stop_cyc, last_en_cyc + 1);
      check("main_frame_cnt", frame_cnt, 2);
      check("main_s_ready_low", s_ready, 0);
      check("main_sof_err", sof_err, 0);
      d0 = done_cnt;
      repeat (50) tick();
      check("main_no_early_done", done_cnt - d0, 0);
      check("main_still_busy", busy, 1);
      enc_sequence_busy = 1'b0;
      fall = cyc;
      wait_done(20);
      check("main_done_latency", last_done_cyc, fall + 1);
      tick();
      check("main_done_one_cycle", done, 0);
      check("main_idle_ready", cfg_ready, 1);
      check("main_frame_cnt_kept", frame_cnt, 2);
      $display("main: enc_en=%0d frame_cnt=%0d", enc_cnt - e0, frame_cnt);

      // Unlimited mode, random valid, abort at beat 700 of the second frame.
      e0 = enc_cnt;
      do_cfg(7'd4, 7'd4, 16'd0);
      stream(50, BPF + 700, -1, 30000);
      check("unl_enc_count", enc_cnt - e0, 2048);
      check("unl_frame_cnt", frame_cnt, 2);
      check("unl_stop_after_en", last_stop_cyc, last_en_cyc + 1);
      wait_done(20);
      $display("unlimited: enc_en=%0d frame_cnt=%0d", enc_cnt - e0, frame_cnt);

      // Encoder busy at configuration time, with a misplaced s_sof on beat 5.
      enc_sequence_busy = 1'b1;
      b0 = beats_acc; e0 = enc_cnt;
      do_cfg(7'd4, 7'd4, 16'd1);
      s_valid = 1'b1;
      repeat (10) tick();
      check("wait_no_beats", beats_acc - b0, 0);
      check("wait_s_ready", s_ready, 0);
      s_valid = 1'b0;
      enc_sequence_busy = 1'b0;
      check("wait_s_ready_same_cycle", s_ready, 0);
      tick();
      check("wait_s_ready_next_cycle", s_ready, 1);
      stream(100, -1, 5, 3000);
      check("sof_enc_count", enc_cnt - e0, 1024);
      check("sof_frame_cnt", frame_cnt, 1);
      check("sof_err_set", sof_err, SOF_EXP);
      wait_done(20);
      check("sof_err_after_done", sof_err, SOF_EXP);
      $display("busy-start/sof: enc_en=%0d sof_err=%0b", enc_cnt - e0, sof_err);

      // Reset after 100 beats.
      do_cfg(7'd4, 7'd4, 16'd0);
      check("sof_err_cleared", sof_err, 0);
      tick();
      b0 = beats_acc; s0 = stop_cnt;
      s_valid = 1'b1;
      for (int n = 0; n < 400 && (beats_acc - b0) < 100; n++) begin
         s_pix = {$urandom(), $urandom(), $urandom()};
         s_sof = ((beats_acc - b0) == 0);
         tick();
      end
      check("rstmid_beats", beats_acc - b0, 100);
      rst = 1'b1;
      tick();
      check("rstmid_cfg_ready", cfg_ready, 1);
      check("rstmid_s_ready", s_ready, 0);
      check("rstmid_enc_en", enc_en, 0);
      check("rstmid_enc_pix", enc_pix, 0);
      check("rstmid_enc_xsize", enc_xsize16, 0);
      check("rstmid_enc_ysize", enc_ysize16, 0);
      check("rstmid_busy", busy, 0);
      check("rstmid_frame_cnt", frame_cnt, 0);
      check("rstmid_stop", enc_sequence_stop, 0);
      rst = 1'b0;
      s_valid = 1'b0;
      repeat (10) tick();
      check("rstmid_no_stop", stop_cnt - s0, 0);
      check("rstmid_queue_empty", exp_q.size(), 0);
      $display("reset-mid: stops=%0d", stop_cnt - s0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mpeg2_sequence_ctrl.md
Name: mpeg2_sequence_ctrl

Overview:
- Sequences one MPEG2 encode sequence through mpeg2encoder.
- Accepts a per-sequence configuration: frame size in 16-pixel units and frame count.
- Forwards 4-pixel YUV444 beats to the encoder while tracking row, column and frame position.
- Issues the single-cycle sequence-stop pulse and waits for the encoder to drain before accepting the next configuration. Sits between the pixel source (DMA/camera) and mpeg2encoder.

Parameters:
- XL, 6, horizontal size field MSB; max width 16<<XL pixels.
- YL, 6, vertical size field MSB; max height 16<<YL pixels.
- FW, 16, width of frame-count fields.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  high only in IDLE.
- cfg_xsize16  in  XL+1  width/16.
- cfg_ysize16  in  YL+1  height/16.
- cfg_nframes  in  FW  frames to encode; 0 = unlimited until abort.
- cfg_err  out  1  one-cycle pulse when a configuration is rejected.
- abort  in  1  request stop at the next frame boundary.
- s_valid  in  1  pixel beat valid.
- s_ready  out  1  pixel beat accepted.
- s_sof  in  1  first beat of frame marker (see Optional Feature).
- s_pix  in  96  {Y0..Y3,U0..U3,V0..V3}, MSB first.
- enc_xsize16  out  XL+1  to encoder.
- enc_ysize16  out  YL+1  to encoder.
- enc_en  out  1  to encoder.
- enc_pix  out  96  to encoder.
- enc_sequence_stop  out  1  to encoder.
- enc_sequence_busy  in  1  from encoder.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on DRAIN->IDLE.
- frame_cnt  out  FW  frames fully forwarded in current sequence.
- sof_err  out  1  sticky alignment error.

Behaviour:
- Reset values: cfg_ready=1, s_ready=0, enc_en=0, enc_pix=0, enc_sequence_stop=0, enc_xsize16=0, enc_ysize16=0, busy=0, done=0, cfg_err=0, frame_cnt=0, sof_err=0. State=IDLE.
- rst mid-sequence aborts immediately with no stop pulse; the encoder is reset alongside.
- States: IDLE, WAIT_ENC, STREAM, STOP, DRAIN.
- IDLE:
  - cfg_valid&cfg_ready with 4<=xsize16<=(1<<XL) and 4<=ysize16<=(1<<YL): latch all cfg fields, drive enc_xsize16/enc_ysize16, clear frame_cnt and sof_err, go to WAIT_ENC.
  - Out-of-range size: cfg_err pulses next cycle, state stays IDLE.
  - abort is ignored in IDLE.
- WAIT_ENC: go to STREAM on the first cycle enc_sequence_busy=0.
- STREAM:
  - s_ready=1 (the encoder has no backpressure).
  - Each accepted beat registers to enc_en=1 and enc_pix=s_pix one cycle later; latency is exactly 1.
  - Column counter cx runs 0..xsize16*4-1, wraps and increments row counter ry, 0..ysize16*16-1. Row wrap increments frame_cnt.
  - Beats per frame = xsize16*ysize16*64.
- abort:
  - Latched while in STREAM.
  - If cx=ry=0 (frame boundary) when abort is seen, s_ready drops the same cycle and the block goes to STOP.
  - Otherwise the current frame completes, then STOP.
  - The boundary check uses counters after the current beat's update. abort coincident with the final beat of a frame stops after that frame.
- Normal end: frame_cnt reaching cfg_nframes (nonzero) on the final beat goes to STOP; s_ready=0 from the next cycle.
- STOP:
  - enc_sequence_stop=1 for exactly one cycle, the cycle after the last enc_en, so it never coincides with enc_en.
  - Zero-frame abort is legal: abort before any beat still pulses stop.
- DRAIN:
  - Hold at least 2 cycles after the stop pulse, then wait for enc_sequence_busy=0.
  - Exit: pulse done and go to IDLE.
  - cfg_valid during DRAIN is held off by cfg_ready=0.
- frame_cnt saturates at all-ones.
- Unlimited mode (nframes=0) ends only on abort.

Optional Feature:
- Macro: MPEG2_SEQ_CTRL_SOF_CHECK_EN.
- Defined:
  - An accepted beat with s_sof=1 when (cx,ry)!=(0,0), or s_sof=0 when (cx,ry)=(0,0), sets sof_err.
  - sof_err stays set until the next accepted cfg.
  - The beat is still forwarded and the counters are not resynchronised.
- Undefined: s_sof is ignored and sof_err is constant 0.

Test Plan:
- cfg 4/4/nframes=2, continuous s_valid:
  - cfg_ready drops 1 cycle after the handshake.
  - Exactly 2048 enc_en pulses, each enc_pix equal to s_pix one cycle earlier.
  - enc_sequence_stop one cycle after the last enc_en.
  - frame_cnt=2.
  - Hold enc_sequence_busy=1 for 50 cycles after stop: done pulses 1 cycle after busy falls.
- cfg_xsize16=3, then cfg_ysize16=(1<<YL)+1: cfg_err pulses each time, busy stays 0, enc_xsize16 is unchanged.
- cfg 4/4/nframes=0 with s_valid toggled randomly:
  - abort at beat 700 of frame 1: forwarding continues to beat 2048 total, then stop.
  - abort again right after cfg with no beats: stop pulse with 0 enc_en.
- enc_sequence_busy=1 when cfg is accepted: s_ready stays 0 until busy=0, then streaming starts the next cycle.
- With MPEG2_SEQ_CTRL_SOF_CHECK_EN, s_sof=1 on beat 5: sof_err=1 and persists through done, clears on the next cfg. Without the macro, same stimulus gives sof_err=0.
- Assert rst at beat 100: all outputs return to reset values next cycle, no enc_sequence_stop emitted.
